pipe_ctrl_decode: RTL and testbench

//  ID-stage control unit for the 5-stage RV32I core. Decodes the IF/ID instruction into the ID/EX

---
 rtl/pipe_ctrl_decode.sv | 224 ++++++++++++++++++++++
 tb/tb_pipe_ctrl_decode.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_decode.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_decode
// ID-stage control unit for a 5-stage RV32I pipeline. Decodes the IF/ID
// instruction into the ID/EX control register, detects load-use hazards,
// applies stall/flush and keeps a saturating count of PC-stall cycles.
//
// Ports
//   clk, rst_n          core clock (rising edge), async active-low reset
//   i_instr, i_valid    IF/ID instruction and its valid flag
//   i_branch_taken      EX redirect this cycle (taken branch / jal / jalr)
//   i_mem_stall         D-cache busy, freeze the whole pipe
//   o_valid             ID/EX holds an instruction (0 = bubble)
//   o_branch .. o_auipc instruction-class flags
//   o_memread .. o_regwrite, o_aluop, o_funct3  datapath controls
//   o_rd, o_rs1, o_rs2  register indices
//   o_illegal           unsupported opcode reached ID/EX
//   o_pc_stall          hold PC and IF/ID (combinational)
//   o_ifid_flush        clear IF/ID (combinational)
//   o_stall_cnt         saturating count of cycles with o_pc_stall=1
// ---------------------------------------------------------------------------
module pipe_ctrl_decode #(
  parameter int BITS   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   i_instr,
  input  logic              i_valid,
  input  logic              i_branch_taken,
  input  logic              i_mem_stall,
  output logic              o_valid,
  output logic              o_branch,
  output logic              o_jal,
  output logic              o_jalr,
  output logic              o_lui,
  output logic              o_auipc,
  output logic              o_memread,
  output logic              o_memwrite,
  output logic              o_memtoreg,
  output logic              o_alusrc,
  output logic              o_regwrite,
  output logic [1:0]        o_aluop,
  output logic [2:0]        o_funct3,
  output logic [REG_AW-1:0] o_rd,
  output logic [REG_AW-1:0] o_rs1,
  output logic [REG_AW-1:0] o_rs2,
  output logic              o_illegal,
  output logic              o_pc_stall,
  output logic              o_ifid_flush,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_rd     = i_instr[7 +: REG_AW];
  assign w_rs1    = i_instr[15 +: REG_AW];
  assign w_rs2    = i_instr[20 +: REG_AW];
  // funct7 is consumed by EX from its own copy of the instruction
  assign w_unused = &{1'b0, i_instr[BITS-1:25]};

  logic       w_branch, w_jal, w_jalr, w_lui, w_auipc;
  logic       w_memread, w_memwrite, w_memtoreg, w_alusrc, w_regwrite;
  logic       w_illegal, w_uses_rs1, w_uses_rs2;
  logic [1:0] w_aluop;

  // Raw opcode decode; gated by i_valid and rd!=0 below
  always_comb begin
    w_branch   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_lui      = 1'b0;
    w_auipc    = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_aluop    = 2'b00;
    case (w_opcode)
      OP_R: begin
        w_regwrite = 1'b1; w_aluop = 2'b10;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b11;
        w_uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        w_memread = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1;
        w_alusrc = 1'b1; w_uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_memwrite = 1'b1; w_alusrc = 1'b1;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_branch = 1'b1; w_aluop = 2'b01;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_jal = 1'b1; w_regwrite = 1'b1;
      end
      OP_JALR: begin
        w_jalr = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        w_lui = 1'b1; w_regwrite = 1'b1;
      end
      OP_AUIPC: begin
        w_auipc = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  logic w_hz;
  logic w_pc_stall;
  logic w_bubble;

  // Only a load still in ID/EX can produce a value too late for forwarding
  assign w_hz = i_valid & o_valid & o_memread & (o_rd != '0) &
                (((o_rd == w_rs1) & w_uses_rs1) | ((o_rd == w_rs2) & w_uses_rs2));

  assign w_pc_stall   = i_mem_stall | (w_hz & ~i_branch_taken);
  assign w_bubble     = i_branch_taken | w_hz;
  assign o_pc_stall   = w_pc_stall;
  assign o_ifid_flush = i_branch_taken & ~i_mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_branch   <= 1'b0;
      o_jal      <= 1'b0;
      o_jalr     <= 1'b0;
      o_lui      <= 1'b0;
      o_auipc    <= 1'b0;
      o_memread  <= 1'b0;
      o_memwrite <= 1'b0;
      o_memtoreg <= 1'b0;
      o_alusrc   <= 1'b0;
      o_regwrite <= 1'b0;
      o_illegal  <= 1'b0;
      o_aluop    <= 2'b00;
      o_funct3   <= 3'b000;
      o_rd       <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
    end else if (i_mem_stall) begin
      // hold everything
    end else if (w_bubble) begin
      o_valid    <= 1'b0;
      o_branch   <= 1'b0;
      o_jal      <= 1'b0;
      o_jalr     <= 1'b0;
      o_lui      <= 1'b0;
      o_auipc    <= 1'b0;
      o_memread  <= 1'b0;
      o_memwrite <= 1'b0;
      o_memtoreg <= 1'b0;
      o_alusrc   <= 1'b0;
      o_regwrite <= 1'b0;
      o_illegal  <= 1'b0;
      o_aluop    <= 2'b00;
      o_funct3   <= 3'b000;
      o_rd       <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
    end else begin
      // i_valid=0 loads an all-zero control word, i.e. a bubble
      o_valid    <= i_valid;
      o_branch   <= i_valid & w_branch;
      o_jal      <= i_valid & w_jal;
      o_jalr     <= i_valid & w_jalr;
      o_lui      <= i_valid & w_lui;
      o_auipc    <= i_valid & w_auipc;
      o_memread  <= i_valid & w_memread;
      o_memwrite <= i_valid & w_memwrite;
      o_memtoreg <= i_valid & w_memtoreg;
      o_alusrc   <= i_valid & w_alusrc;
      o_regwrite <= i_valid & w_regwrite & (w_rd != '0);
      o_illegal  <= i_valid & w_illegal;
      o_aluop    <= i_valid ? w_aluop : 2'b00;
      o_funct3   <= w_funct3;
      o_rd       <= w_rd;
      o_rs1      <= w_rs1;
      o_rs2      <= w_rs2;
    end
  end

  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_pc_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_decode.sv
module tb_pipe_ctrl_decode;

  // ctrl word: {valid,branch,jal,jalr,lui,auipc,memread,memwrite,memtoreg,alusrc,regwrite,illegal,aluop[1:0]}
  localparam logic [13:0] C_BUB   = 14'b0_00000_0_0_0_0_0_0_00;
  localparam logic [13:0] C_LW    = 14'b1_00000_1_0_1_1_1_0_00;
  localparam logic [13:0] C_LWX0  = 14'b1_00000_1_0_1_1_0_0_00;
  localparam logic [13:0] C_R     = 14'b1_00000_0_0_0_0_1_0_10;
  localparam logic [13:0] C_BEQ   = 14'b1_10000_0_0_0_0_0_0_01;
  localparam logic [13:0] C_ADDI0 = 14'b1_00000_0_0_0_1_0_0_11;
  localparam logic [13:0] C_ILL   = 14'b1_00000_0_0_0_0_0_1_00;
  localparam logic [13:0] C_SW    = 14'b1_00000_0_1_0_1_0_0_00;
  localparam logic [13:0] C_LUI   = 14'b1_00010_0_0_0_0_1_0_00;
  localparam logic [13:0] C_JALR  = 14'b1_00100_0_0_0_1_1_0_00;
  localparam logic [13:0] C_AUIPC = 14'b1_00001_0_0_0_1_1_0_00;
  localparam logic [13:0] C_JAL   = 14'b1_01000_0_0_0_0_1_0_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] i_instr = '0;
  logic i_valid = 1'b0, i_branch_taken = 1'b0, i_mem_stall = 1'b0;
  logic o_valid, o_branch, o_jal, o_jalr, o_lui, o_auipc;
  logic o_memread, o_memwrite, o_memtoreg, o_alusrc, o_regwrite, o_illegal;
  logic [1:0] o_aluop;
  logic [2:0] o_funct3;
  logic [4:0] o_rd, o_rs1, o_rs2;
  logic o_pc_stall, o_ifid_flush;
  logic [15:0] o_stall_cnt;

  logic s_mst = 1'b0;
  logic s_valid, s_branch, s_jal, s_jalr, s_lui, s_auipc;
  logic s_memread, s_memwrite, s_memtoreg, s_alusrc, s_regwrite, s_illegal;
  logic [1:0] s_aluop;
  logic [2:0] s_funct3;
  logic [4:0] s_rd, s_rs1, s_rs2;
  logic s_pc_stall, s_ifid_flush;
  logic [1:0] s_stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl_decode #(.BITS(32), .REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_instr(i_instr), .i_valid(i_valid),
    .i_branch_taken(i_branch_taken), .i_mem_stall(i_mem_stall),
    .o_valid(o_valid), .o_branch(o_branch), .o_jal(o_jal), .o_jalr(o_jalr),
    .o_lui(o_lui), .o_auipc(o_auipc), .o_memread(o_memread), .o_memwrite(o_memwrite),
    .o_memtoreg(o_memtoreg), .o_alusrc(o_alusrc), .o_regwrite(o_regwrite),
    .o_aluop(o_aluop), .o_funct3(o_funct3), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_illegal(o_illegal), .o_pc_stall(o_pc_stall), .o_ifid_flush(o_ifid_flush),
    .o_stall_cnt(o_stall_cnt)
  );

  pipe_ctrl_decode #(.BITS(32), .REG_AW(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_instr(32'h0), .i_valid(1'b0),
    .i_branch_taken(1'b0), .i_mem_stall(s_mst),
    .o_valid(s_valid), .o_branch(s_branch), .o_jal(s_jal), .o_jalr(s_jalr),
    .o_lui(s_lui), .o_auipc(s_auipc), .o_memread(s_memread), .o_memwrite(s_memwrite),
    .o_memtoreg(s_memtoreg), .o_alusrc(s_alusrc), .o_regwrite(s_regwrite),
    .o_aluop(s_aluop), .o_funct3(s_funct3), .o_rd(s_rd), .o_rs1(s_rs1), .o_rs2(s_rs2),
    .o_illegal(s_illegal), .o_pc_stall(s_pc_stall), .o_ifid_flush(s_ifid_flush),
    .o_stall_cnt(s_stall_cnt)
  );

  wire [13:0] w_ctrl = {o_valid, o_branch, o_jal, o_jalr, o_lui, o_auipc, o_memread,
                        o_memwrite, o_memtoreg, o_alusrc, o_regwrite, o_illegal, o_aluop};
  wire [17:0] w_idx  = {o_funct3, o_rd, o_rs1, o_rs2};

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        br;
    logic        mst;
    logic [1:0]  exp_sf;   // {o_pc_stall, o_ifid_flush} before the edge
    logic [13:0] exp_ctrl; // after the edge
    logic [17:0] exp_idx;  // {funct3,rd,rs1,rs2}, checked only when exp valid
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [17:0] idx(input int f3, input int rd, input int rs1, input int rs2);
    return {3'(f3), 5'(rd), 5'(rs1), 5'(rs2)};
  endfunction

  initial begin
    vt[0]  = '{32'h0000A283, 1, 0, 0, 2'b00, C_LW,    idx(2,5,1,0), 16'd0};
    vt[1]  = '{32'h00228333, 1, 0, 0, 2'b10, C_BUB,   idx(0,0,0,0), 16'd1};
    vt[2]  = '{32'h00228333, 1, 0, 0, 2'b00, C_R,     idx(0,6,5,2), 16'd1};
    vt[3]  = '{32'h0000A283, 1, 0, 0, 2'b00, C_LW,    idx(2,5,1,0), 16'd1};
    vt[4]  = '{32'h00228333, 1, 1, 0, 2'b01, C_BUB,   idx(0,0,0,0), 16'd1};
    vt[5]  = '{32'h00000063, 1, 0, 0, 2'b00, C_BEQ,   idx(0,0,0,0), 16'd1};
    vt[6]  = '{32'h00000013, 1, 1, 1, 2'b10, C_BEQ,   idx(0,0,0,0), 16'd2};
    vt[7]  = '{32'h00000013, 1, 1, 1, 2'b10, C_BEQ,   idx(0,0,0,0), 16'd3};
    vt[8]  = '{32'h00000013, 1, 1, 1, 2'b10, C_BEQ,   idx(0,0,0,0), 16'd4};
    vt[9]  = '{32'h00000013, 1, 0, 0, 2'b00, C_ADDI0, idx(0,0,0,0), 16'd4};
    vt[10] = '{32'h0000007F, 1, 0, 0, 2'b00, C_ILL,   idx(0,0,0,0), 16'd4};
    vt[11] = '{32'h0000A283, 0, 0, 0, 2'b00, C_BUB,   idx(0,0,0,0), 16'd4};
    vt[12] = '{32'h0000A283, 1, 0, 0, 2'b00, C_LW,    idx(2,5,1,0), 16'd4};
    vt[13] = '{32'h0050A023, 1, 0, 0, 2'b10, C_BUB,   idx(0,0,0,0), 16'd5};
    vt[14] = '{32'h0050A023, 1, 0, 0, 2'b00, C_SW,    idx(2,0,1,5), 16'd5};
    vt[15] = '{32'h00012083, 1, 0, 0, 2'b00, C_LW,    idx(2,1,2,0), 16'd5};
    vt[16] = '{32'h000081B7, 1, 0, 0, 2'b00, C_LUI,   idx(0,3,1,0), 16'd5};
    vt[17] = '{32'h000080E7, 1, 0, 0, 2'b00, C_JALR,  idx(0,1,1,0), 16'd5};
    vt[18] = '{32'h00000217, 1, 0, 0, 2'b00, C_AUIPC, idx(0,4,0,0), 16'd5};
    vt[19] = '{32'h000000EF, 1, 0, 0, 2'b00, C_JAL,   idx(0,1,0,0), 16'd5};
    vt[20] = '{32'h0000A003, 1, 0, 0, 2'b00, C_LWX0,  idx(2,0,1,0), 16'd5};
    vt[21] = '{32'h00000333, 1, 0, 0, 2'b00, C_R,     idx(0,6,0,0), 16'd5};

    // reset state, no clock edge taken yet
    #1;
    chk("reset_ctrl", 32'(w_ctrl), 32'(C_BUB));
    chk("reset_idx", 32'(w_idx), 0);
    chk("reset_cnt", 32'(o_stall_cnt), 0);
    chk("reset_sf", {30'd0, o_pc_stall, o_ifid_flush}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", 32'(o_valid), 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      i_instr = vt[i].instr; i_valid = vt[i].vld;
      i_branch_taken = vt[i].br; i_mem_stall = vt[i].mst;
      #1;
      chk($sformatf("v%0d_stall_flush", i), {30'd0, o_pc_stall, o_ifid_flush}, 32'(vt[i].exp_sf));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ctrl", i), 32'(w_ctrl), 32'(vt[i].exp_ctrl));
      if (vt[i].exp_ctrl[13])
        chk($sformatf("v%0d_idx", i), 32'(w_idx), 32'(vt[i].exp_idx));
      chk($sformatf("v%0d_cnt", i), 32'(o_stall_cnt), 32'(vt[i].exp_cnt));
    end

    // asynchronous reset mid-stream, checked before any clock edge
    @(negedge clk);
    i_instr = 32'h0000A283; i_valid = 1'b1; i_branch_taken = 1'b0; i_mem_stall = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'(w_ctrl), 32'(C_BUB));
    chk("midrst_idx", 32'(w_idx), 0);
    chk("midrst_cnt", 32'(o_stall_cnt), 0);
    chk("midrst_sf", {30'd0, o_pc_stall, o_ifid_flush}, 0);
    @(negedge clk);
    rst_n = 1'b1; i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_valid%0d", k), 32'(o_valid), 0);
    end
    @(negedge clk);
    i_instr = 32'h00228333; i_valid = 1'b1;
    @(posedge clk); #1;
    chk("first_after_rst_ctrl", 32'(w_ctrl), 32'(C_R));
    chk("first_after_rst_rd", 32'(o_rd), 6);
    @(negedge clk); i_valid = 1'b0;

    // saturation of a 2-bit stall counter
    chk("sat_start", 32'(s_stall_cnt), 0);
    @(negedge clk); s_mst = 1'b1;
    #1 chk("sat_pc_stall", 32'(s_pc_stall), 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_cnt%0d", k), 32'(s_stall_cnt), (k < 3) ? k : 3);
    end
    @(negedge clk); s_mst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
